// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg : shared types for the two-port to one-port memory arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_arbiter_pkg;

  typedef logic [15:0] lc3b_word;

  typedef struct packed {
    logic       read;
    logic       write;
    logic [1:0] wmask;
    lc3b_word   address;
    lc3b_word   wdata;
  } lc3b_mem_req;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_BUSY_A = 3'd1,
    ARB_BUSY_B = 3'd2,
    ARB_DONE_A = 3'd3,
    ARB_DONE_B = 3'd4
  } lc3b_arb_state;

  // A request with both strobes high is treated as a write.
  function automatic lc3b_mem_req make_req(input logic rd, input logic wr,
                                           input logic [1:0] mask,
                                           input lc3b_word addr, input lc3b_word data);
    lc3b_mem_req r;
    r.read    = rd & ~wr;
    r.write   = wr;
    r.wmask   = mask;
    r.address = addr;
    r.wdata   = data;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if : one memory request/response channel
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic       read;
  logic       write;
  logic [1:0] wmask;
  lc3b_word   address;
  lc3b_word   wdata;
  logic       resp;
  lc3b_word   rdata;

  modport master (output read, output write, output wmask, output address, output wdata,
                  input  resp, input  rdata);

  modport slave  (input  read, input  write, input  wmask, input  address, input  wdata,
                  output resp, output rdata);
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter : serialises ports A and B onto one pmem port, with watchdog
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  a,
  mem_arbiter_if.slave  b,
  mem_arbiter_if.master pmem,
  output logic          timeout_err
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

  lc3b_arb_state    state;
  lc3b_mem_req      lat;
  logic             last_b;
  logic [CNT_W-1:0] cnt;
  lc3b_word         a_rdata_reg;
  lc3b_word         b_rdata_reg;

  logic req_a;
  logic req_b;
  logic grant_a;
  logic grant_b;
  logic busy;
  logic serving_a;

  assign req_a     = a.read | a.write;
  assign req_b     = b.read | b.write;
  // On contention the port that did not win last time goes next.
  assign grant_b   = req_b & (~req_a | ~last_b);
  assign grant_a   = req_a & ~grant_b;
  assign busy      = (state == ARB_BUSY_A) || (state == ARB_BUSY_B);
  assign serving_a = (state == ARB_BUSY_A);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      lat         <= '0;
      last_b      <= 1'b0;
      cnt         <= '0;
      a_rdata_reg <= '0;
      b_rdata_reg <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_b) begin
            lat    <= make_req(b.read, b.write, b.wmask, b.address, b.wdata);
            last_b <= 1'b1;
            cnt    <= '0;
            state  <= ARB_BUSY_B;
          end else if (grant_a) begin
            lat    <= make_req(a.read, a.write, a.wmask, a.address, a.wdata);
            last_b <= 1'b0;
            cnt    <= '0;
            state  <= ARB_BUSY_A;
          end
        end
        ARB_BUSY_A, ARB_BUSY_B: begin
          if (pmem.resp) begin
            if (serving_a) a_rdata_reg <= pmem.rdata;
            else           b_rdata_reg <= pmem.rdata;
            state <= serving_a ? ARB_DONE_A : ARB_DONE_B;
          end else if ((TIMEOUT_CYC != 0) && (cnt == CNT_LAST)) begin
            if (serving_a) a_rdata_reg <= '0;
            else           b_rdata_reg <= '0;
            timeout_err <= 1'b1;
            state       <= serving_a ? ARB_DONE_A : ARB_DONE_B;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ARB_DONE_A, ARB_DONE_B: state <= ARB_IDLE;
        default:                state <= ARB_IDLE;
      endcase
    end
  end

  // Strobes are gated by state so an asynchronous reset drops them at once.
  assign pmem.read    = busy & lat.read;
  assign pmem.write   = busy & lat.write;
  assign pmem.wmask   = lat.wmask;
  assign pmem.address = lat.address;
  assign pmem.wdata   = lat.wdata;

  assign a.resp  = (state == ARB_DONE_A);
  assign a.rdata = a_rdata_reg;
  assign b.resp  = (state == ARB_DONE_B);
  assign b.rdata = b_rdata_reg;

endmodule

`default_nettype wire
